// File: rtl/spi_device_pkg.sv
// rtl/spi_device_pkg.sv - shared types and constants for the SPI device byte engine
package spi_device_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_dev_state_e;

    localparam int SpiByteW = 8;

endpackage

// File: rtl/spi_device_byte_if.sv
// rtl/spi_device_byte_if.sv - rx/tx byte streams between the SPI device and its bus wrapper
interface spi_device_byte_if;
    import spi_device_pkg::*;

    logic [SpiByteW-1:0] rx_data_o;
    logic                rx_valid_o;
    logic                rx_ready_i;
    logic [SpiByteW-1:0] tx_data_i;
    logic                tx_valid_i;
    logic                tx_ready_o;

    modport slave (
        output rx_data_o, rx_valid_o, tx_ready_o,
        input  rx_ready_i, tx_data_i, tx_valid_i
    );

    modport master (
        input  rx_data_o, rx_valid_o, tx_ready_o,
        output rx_ready_i, tx_data_i, tx_valid_i
    );

endinterface

// File: rtl/spi_device_sync.sv
// rtl/spi_device_sync.sv - N-stage synchroniser with one-cycle edge detector
module spi_device_sync #(
    parameter int   Stages   = 2,
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign rise_o =  sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] &  prev_q;

endmodule

// File: rtl/spi_device_byte.sv
// rtl/spi_device_byte.sv - mode-0 SPI target, MSB first, byte streams on valid/ready
module spi_device_byte
    import spi_device_pkg::*;
#(
    parameter int                  SyncStages = 2,
    parameter logic [SpiByteW-1:0] IdleByte   = 8'hFF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               spi_sck_i,
    input  logic               spi_csn_i,
    input  logic               spi_sdi_i,
    output logic               spi_sdo_o,
    output logic               spi_sdo_en_o,
    spi_device_byte_if.slave   strm,
    output logic               rx_overflow_o,
    output logic               tx_underrun_o,
    output logic               busy_o
);

    logic sck_rise, sck_fall, csn_rise, csn_fall;
    logic [SyncStages-1:0] sdi_sync_q;
    logic sdi_s;

    spi_device_sync #(.Stages(SyncStages), .ResetVal(1'b0)) u_sck_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_device_sync #(.Stages(SyncStages), .ResetVal(1'b1)) u_csn_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_csn_i), .rise_o(csn_rise), .fall_o(csn_fall)
    );

    spi_dev_state_e      state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [SpiByteW-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [SpiByteW-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
    logic                rx_valid_q, rx_valid_d, hold_full_q, hold_full_d;
    logic                sdo_en_q, sdo_en_d, ovf_q, ovf_d, unr_q, unr_d, busy_q, busy_d;
    logic                load, byte_done, rx_accept, tx_write;
    logic [SpiByteW-1:0] rx_byte;

    assign sdi_s = sdi_sync_q[SyncStages-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        hold_d      = hold_q;
        sdo_en_d    = sdo_en_q;
        busy_d      = busy_q;
        ovf_d       = 1'b0;
        unr_d       = 1'b0;
        load        = 1'b0;
        byte_done   = 1'b0;
        rx_byte     = {rx_shift_q[SpiByteW-2:0], sdi_s};

        if (csn_rise) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            rx_shift_d = '0;
            sdo_en_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d  = SHIFT;
                        cnt_d    = 3'd0;
                        load     = 1'b1;
                        sdo_en_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_shift_d = rx_byte;
                        cnt_d      = cnt_q + 3'd1;
                        byte_done  = (cnt_q == 3'd7);
                    end else if (sck_fall) begin
                        // count==0 on a fall means the previous byte just ended
                        if (cnt_q != 3'd0) begin
                            tx_shift_d = {tx_shift_q[SpiByteW-2:0], 1'b1};
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = IdleByte;
                unr_d      = 1'b1;
            end
        end

        rx_accept = rx_valid_q & strm.rx_ready_i;
        if (rx_accept) begin
            rx_valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!rx_valid_q || rx_accept) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // the load above only sees the registered holding state, so a same-cycle write waits
        tx_write    = strm.tx_valid_i & ~hold_full_q;
        hold_full_d = tx_write | (hold_full_q & ~load);
        if (tx_write) begin
            hold_d = strm.tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sdi_sync_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rx_shift_q  <= '0;
            tx_shift_q  <= IdleByte;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sdo_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            unr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sdi_sync_q  <= {sdi_sync_q[SyncStages-2:0], spi_sdi_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sdo_en_q    <= sdo_en_d;
            ovf_q       <= ovf_d;
            unr_q       <= unr_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_sdo_o       = sdo_en_q ? tx_shift_q[SpiByteW-1] : 1'b1;
    assign spi_sdo_en_o    = sdo_en_q;
    assign strm.rx_data_o  = rx_data_q;
    assign strm.rx_valid_o = rx_valid_q;
    assign strm.tx_ready_o = ~hold_full_q;
    assign rx_overflow_o   = ovf_q;
    assign tx_underrun_o   = unr_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_spi_device_byte.sv
// tb/tb_spi_device_byte.sv - scoreboard bench for spi_device_byte with a frame-level host model
module tb_spi_device_byte;
    import spi_device_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic csn = 1'b1;
    logic sdi = 1'b0;
    logic sdo, sdo_en, ovf, unr, busy;

    spi_device_byte_if strm();

    spi_device_byte #(.SyncStages(2), .IdleByte(8'hFF)) dut (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi_i(sdi),
        .spi_sdo_o(sdo), .spi_sdo_en_o(sdo_en), .strm(strm),
        .rx_overflow_o(ovf), .tx_underrun_o(unr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0, unr_cnt = 0, exp_ovf = 0, exp_unr = 0;
    logic [7:0] exp_rx_q[$], exp_miso_q[$], mosi_q[$], m_hold[$];
    bit m_rx_occ = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: pulse counters and rx scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ovf) ovf_cnt++;
            if (unr) unr_cnt++;
            if (strm.rx_valid_o && strm.rx_ready_i) begin
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h expected=none", strm.rx_data_o);
                end else begin
                    check("rx_data", {24'd0, strm.rx_data_o}, {24'd0, exp_rx_q.pop_front()});
                end
            end
        end
    end

    // reference model: one load per byte slot, one rx slot that holds until read
    function automatic void model_load();
        if (m_hold.size() > 0) begin
            exp_miso_q.push_back(m_hold.pop_front());
        end else begin
            exp_miso_q.push_back(8'hFF);
            exp_unr++;
        end
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (strm.rx_ready_i) begin
            exp_rx_q.push_back(b);
        end else if (!m_rx_occ) begin
            exp_rx_q.push_back(b);
            m_rx_occ = 1;
        end else begin
            exp_ovf++;
        end
    endfunction

    function automatic void plan_full_frame();
        foreach (mosi_q[i]) begin
            model_load();
            model_rx(mosi_q[i]);
        end
    endfunction

    task automatic tx_write(input logic [7:0] b);
        int n = 0;
        while (!strm.tx_ready_o && n < 200) begin
            cyc(1);
            n++;
        end
        check("tx_ready_wait", {31'd0, strm.tx_ready_o}, 32'd1);
        strm.tx_data_i  = b;
        strm.tx_valid_i = 1'b1;
        cyc(1);
        strm.tx_valid_i = 1'b0;
        m_hold.push_back(b);
    endtask

    // host: SCK period = 8 clk; last fall coincides with CSN rise
    task automatic host_frame(input int nbits);
        logic [7:0] sb, rb;
        sb = 8'h00;
        rb = 8'h00;
        csn = 1'b0;
        cyc(8);
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) sb = mosi_q[i / 8];
            sdi = sb[7 - (i % 8)];
            cyc(4);
            sck = 1'b1;
            rb = {rb[6:0], sdo};
            if (i % 8 == 7) begin
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected actual=%0h expected=none", rb);
                end else begin
                    check("miso", {24'd0, rb}, {24'd0, exp_miso_q.pop_front()});
                end
            end
            cyc(4);
            sck = 1'b0;
            if (i == nbits - 1) csn = 1'b1;
        end
        cyc(12);
        mosi_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        strm.rx_ready_i = 1'b1;
        while (exp_rx_q.size() != 0 && n < 50) begin
            cyc(1);
            n++;
        end
        check("drain_empty", exp_rx_q.size(), 0);
        m_rx_occ = 0;
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        strm.rx_ready_i = 1'b0;
        strm.tx_data_i  = 8'h00;
        strm.tx_valid_i = 1'b0;
        cyc(5);
        rst = 1'b0;
        cyc(1);
        check("rst_sdo", {31'd0, sdo}, 32'd1);
        check("rst_sdo_en", {31'd0, sdo_en}, 32'd0);
        check("rst_rx_valid", {31'd0, strm.rx_valid_o}, 32'd0);
        check("rst_rx_data", {24'd0, strm.rx_data_o}, 32'd0);
        check("rst_tx_ready", {31'd0, strm.tx_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // single byte, preloaded tx
        tx_write(8'h3C);
        mosi_q = {8'hA5};
        plan_full_frame();
        host_frame(8);
        check("t1_rx_valid", {31'd0, strm.rx_valid_o}, 32'd1);
        check("t1_rx_data", {24'd0, strm.rx_data_o}, 32'hA5);
        drain();
        check("t1_unr", unr_cnt, exp_unr);
        check("t1_ovf", ovf_cnt, exp_ovf);

        // back-to-back bytes with underrun
        strm.rx_ready_i = 1'b1;
        tx_write(8'h55);
        mosi_q = {8'h01, 8'h02, 8'h03};
        plan_full_frame();
        host_frame(24);
        check("t2_unr", unr_cnt, exp_unr);
        check("t2_unr_two", exp_unr, 2);

        // overflow
        strm.rx_ready_i = 1'b0;
        mosi_q = {8'h11, 8'h22};
        plan_full_frame();
        host_frame(16);
        check("t3_rx_data", {24'd0, strm.rx_data_o}, 32'h11);
        check("t3_ovf", ovf_cnt, exp_ovf);
        check("t3_ovf_one", exp_ovf, 1);
        drain();

        // aborted frame then full frame
        strm.rx_ready_i = 1'b1;
        mosi_q = {8'hF0};
        model_load();
        void'(exp_miso_q.pop_back());
        host_frame(4);
        check("t4_busy_gap", {31'd0, busy}, 32'd0);
        mosi_q = {8'h0F};
        plan_full_frame();
        host_frame(8);
        check("t4_unr", unr_cnt, exp_unr);

        // write in the same cycle as the CSN-fall load
        mosi_q = {8'h6A, 8'h95};
        model_load();
        model_rx(8'h6A);
        m_hold.push_back(8'h77);
        model_load();
        model_rx(8'h95);
        fork
            host_frame(16);
            begin
                cyc(2);
                strm.tx_data_i  = 8'h77;
                strm.tx_valid_i = 1'b1;
                cyc(1);
                strm.tx_valid_i = 1'b0;
            end
        join
        check("t5_unr", unr_cnt, exp_unr);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom));
            plan_full_frame();
            host_frame(nb * 8);
        end
        check("rand_unr", unr_cnt, exp_unr);
        check("rand_ovf", ovf_cnt, exp_ovf);
        cyc(4);

        // reset mid-frame with a pending rx byte and full holding register
        strm.rx_ready_i = 1'b0;
        mosi_q = {8'h3E};
        plan_full_frame();
        host_frame(8);
        check("t6_pending", {31'd0, strm.rx_valid_o}, 32'd1);
        tx_write(8'h99);
        model_load();
        void'(exp_miso_q.pop_back());
        csn = 1'b0;
        cyc(8);
        tx_write(8'h66);
        check("t6_full", {31'd0, strm.tx_ready_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            sdi = i[0];
            cyc(4);
            sck = 1'b1;
            if (i >= 3) check("t6_sdo_idle", {31'd0, sdo}, 32'd1);
            cyc(4);
            sck = 1'b0;
            if (i == 2) begin
                rst = 1'b1;
                cyc(1);
                check("t6_rx_valid", {31'd0, strm.rx_valid_o}, 32'd0);
                check("t6_tx_ready", {31'd0, strm.tx_ready_o}, 32'd1);
                check("t6_sdo_en", {31'd0, sdo_en}, 32'd0);
                exp_rx_q.delete();
                m_hold.delete();
                m_rx_occ = 0;
            end
        end
        csn = 1'b1;
        cyc(4);
        rst = 1'b0;
        cyc(8);

        // frame after reset
        strm.rx_ready_i = 1'b1;
        tx_write(8'h5A);
        mosi_q = {8'($urandom)};
        plan_full_frame();
        host_frame(8);
        cyc(4);
        check("end_rx_q", exp_rx_q.size(), 0);
        check("end_miso_q", exp_miso_q.size(), 0);
        check("end_unr", unr_cnt, exp_unr);
        check("end_ovf", ovf_cnt, exp_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
